// File: rtl/pc_fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_if
// Bundles the three buses the fetch sequencer talks over:
//   PC register  : pc_we, pc_next (to register), pc_value (from register)
//   instr memory : mem_req, mem_addr (to memory), mem_ack, mem_rdata (back)
//   decoder      : instr_valid, instr_out (to decoder),
//                  instr_ready, jump_valid, jump_target (back)
// master = sequencer side, slave = environment side (PC reg, memory, decoder).
// ---------------------------------------------------------------------------
interface pc_fetch_sequencer_if;
    logic       pc_we;
    logic [7:0] pc_next;
    logic [7:0] pc_value;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic [7:0] instr_out;
    logic       instr_ready;
    logic       jump_valid;
    logic [7:0] jump_target;

    modport master (
        output pc_we, pc_next, mem_req, mem_addr, instr_valid, instr_out,
        input  pc_value, mem_ack, mem_rdata, instr_ready, jump_valid, jump_target
    );

    modport slave (
        input  pc_we, pc_next, mem_req, mem_addr, instr_valid, instr_out,
        output pc_value, mem_ack, mem_rdata, instr_ready, jump_valid, jump_target
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
// Walks the core through FETCH -> DISPATCH -> UPDATE1 -> UPDATE2 per
// instruction: fetches the byte at pc_value, hands it to the decoder, then
// writes the next PC (pc_value+1 or the decoder's jump target) into the PC
// register. Owns start (run) / stop (halt_req) control and a fetch timeout
// that parks the block in a sticky FAULT state until rst.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   run       : level, core may execute
//   halt_req  : pulse, stop after the in-flight instruction completes
//   bus       : pc_fetch_sequencer_if.master (PC register, memory, decoder)
//   busy      : not in IDLE/FAULT
//   fault     : fetch timeout seen, sticky until rst
//   retired   : instructions completed since reset (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int unsigned FETCH_TIMEOUT = 15,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        halt_req,
    pc_fetch_sequencer_if.master        bus,
    output logic                        busy,
    output logic                        fault,
    output logic [COUNT_W-1:0]          retired
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_UPDATE1  = 3'd3,
        ST_UPDATE2  = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    // Last counter value before the timeout fires (counter counts ack-less FETCH cycles).
    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t               state_r, state_n;
    logic [7:0]           cnt_r, cnt_n;
    logic                 halt_pend_r, halt_pend_n;
    logic                 load_instr_s;
    logic                 load_next_s;
    logic                 retire_s;
    logic [7:0]           next_pc_s;

    logic                 pc_we_r;
    logic [7:0]           pc_next_r;
    logic                 mem_req_r;
    logic                 instr_valid_r;
    logic [7:0]           instr_out_r;
    logic                 busy_r;
    logic                 fault_r;
    logic [COUNT_W-1:0]   retired_r;

    // Next-state, timeout counter, halt bookkeeping and datapath load strobes.
    always_comb begin
        state_n      = state_r;
        cnt_n        = 8'd0;
        halt_pend_n  = halt_pend_r;
        load_instr_s = 1'b0;
        load_next_s  = 1'b0;
        retire_s     = 1'b0;
        next_pc_s    = bus.jump_valid ? bus.jump_target : (bus.pc_value + 8'd1);

        // A halt request while an instruction is in flight is remembered;
        // in IDLE/FAULT it is simply dropped.
        if (halt_req && (state_r != ST_IDLE) && (state_r != ST_FAULT)) begin
            halt_pend_n = 1'b1;
        end else begin
            halt_pend_n = halt_pend_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (run && !halt_req) begin
                    state_n = ST_FETCH;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    load_instr_s = 1'b1;
                    state_n      = ST_DISPATCH;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_n = ST_FAULT;
                end else begin
                    cnt_n = cnt_r + 8'd1;
                end
            end
            ST_DISPATCH: begin
                if (bus.instr_ready) begin
                    load_next_s = 1'b1;
                    state_n     = ST_UPDATE1;
                end else begin
                    state_n = ST_DISPATCH;
                end
            end
            ST_UPDATE1: begin
                state_n = ST_UPDATE2;
            end
            ST_UPDATE2: begin
                retire_s    = 1'b1;
                halt_pend_n = 1'b0;
                // halt_req arriving on this very cycle still counts.
                if (halt_pend_r || halt_req || !run) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
            default: begin
                state_n     = ST_IDLE;
                halt_pend_n = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from state_n
    // so they line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            halt_pend_r   <= 1'b0;
            pc_we_r       <= 1'b0;
            pc_next_r     <= 8'd0;
            mem_req_r     <= 1'b0;
            instr_valid_r <= 1'b0;
            instr_out_r   <= 8'd0;
            busy_r        <= 1'b0;
            fault_r       <= 1'b0;
            retired_r     <= '0;
        end else begin
            state_r       <= state_n;
            cnt_r         <= cnt_n;
            halt_pend_r   <= halt_pend_n;
            // The PC register drops the first write cycle, so we is held across both UPDATE states.
            pc_we_r       <= (state_n == ST_UPDATE1) || (state_n == ST_UPDATE2);
            mem_req_r     <= (state_n == ST_FETCH);
            instr_valid_r <= (state_n == ST_DISPATCH);
            busy_r        <= (state_n != ST_IDLE) && (state_n != ST_FAULT);
            fault_r       <= fault_r || (state_n == ST_FAULT);
            if (load_instr_s) begin
                instr_out_r <= bus.mem_rdata;
            end
            if (load_next_s) begin
                pc_next_r <= next_pc_s;
            end
            if (retire_s) begin
                retired_r <= retired_r + COUNT_W'(1);
            end
        end
    end

    assign bus.pc_we       = pc_we_r;
    assign bus.pc_next     = pc_next_r;
    assign bus.mem_req     = mem_req_r;
    assign bus.mem_addr    = mem_req_r ? bus.pc_value : 8'h00;
    assign bus.instr_valid = instr_valid_r;
    assign bus.instr_out   = instr_out_r;
    assign busy            = busy_r;
    assign fault           = fault_r;
    assign retired         = retired_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Directed bench: drives run/halt, a PC register that ignores the first
// write-enable cycle, a memory returning addr ^ 8'h5A, and a decoder.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        halt_req;
    logic        busy;
    logic        fault;
    logic [15:0] retired;

    logic [7:0]  pc_q;
    logic        we_d;
    int          n_checks;
    int          n_pass;
    int          exp_retired;

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer #(
        .FETCH_TIMEOUT (15),
        .COUNT_W       (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .halt_req (halt_req),
        .bus      (bus),
        .busy     (busy),
        .fault    (fault),
        .retired  (retired)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content: instruction byte = address ^ 8'h5A.
    assign bus.mem_rdata = bus.mem_addr ^ 8'h5A;
    assign bus.pc_value  = pc_q;

    // PC register model: a write lands only on the second consecutive we cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= 8'h00;
            we_d <= 1'b0;
        end else begin
            we_d <= bus.pc_we;
            if (bus.pc_we && we_d) begin
                pc_q <= bus.pc_next;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One instruction, entered with the DUT already in FETCH; returns in UPDATE2.
    task automatic do_instr(input logic [7:0] pc, input int ack_dly, input int rdy_dly,
                            input logic jv, input logic [7:0] jt, input logic hlt,
                            input logic [7:0] nxt);
        halt_req    = hlt;
        bus.mem_ack = (ack_dly == 0);
        check_eq("fetch_req", bus.mem_req, 1);
        check_eq("fetch_addr", bus.mem_addr, pc);
        check_eq("fetch_we", bus.pc_we, 0);
        check_eq("fetch_busy", busy, 1);
        for (int i = 0; i < ack_dly; i++) begin
            tick;
            halt_req    = 1'b0;
            bus.mem_ack = (i == ack_dly - 1);
            check_eq("fetch_hold", bus.mem_req, 1);
            check_eq("fetch_novalid", bus.instr_valid, 0);
        end
        tick;
        halt_req        = 1'b0;
        bus.mem_ack     = 1'b1;
        bus.instr_ready = (rdy_dly == 0);
        bus.jump_valid  = (rdy_dly == 0) ? jv : 1'b1;
        bus.jump_target = (rdy_dly == 0) ? jt : 8'hEE;
        check_eq("disp_valid", bus.instr_valid, 1);
        check_eq("disp_instr", bus.instr_out, pc ^ 8'h5A);
        check_eq("disp_we", bus.pc_we, 0);
        check_eq("disp_noreq", bus.mem_req, 0);
        for (int i = 0; i < rdy_dly; i++) begin
            tick;
            bus.instr_ready = (i == rdy_dly - 1);
            bus.jump_valid  = (i == rdy_dly - 1) ? jv : 1'b1;
            bus.jump_target = (i == rdy_dly - 1) ? jt : 8'hEE;
            check_eq("stall_valid", bus.instr_valid, 1);
            check_eq("stall_instr", bus.instr_out, pc ^ 8'h5A);
            check_eq("stall_we", bus.pc_we, 0);
        end
        tick;
        bus.instr_ready = 1'b0;
        bus.jump_valid  = 1'b0;
        bus.jump_target = 8'h00;
        bus.mem_ack     = 1'b0;
        check_eq("upd1_we", bus.pc_we, 1);
        check_eq("upd1_next", bus.pc_next, nxt);
        check_eq("upd1_novalid", bus.instr_valid, 0);
        check_eq("upd1_pc_old", bus.pc_value, pc);
        tick;
        check_eq("upd2_we", bus.pc_we, 1);
        check_eq("upd2_next", bus.pc_next, nxt);
        check_eq("upd2_pc_old", bus.pc_value, pc);
        exp_retired++;
    endtask

    // Watchdog: the run is fully directed, this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        exp_retired     = 0;
        rst             = 1'b1;
        run             = 1'b0;
        halt_req        = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b0;
        bus.jump_valid  = 1'b0;
        bus.jump_target = 8'h00;
        #3;
        check_eq("rst_we", bus.pc_we, 0);
        check_eq("rst_next", bus.pc_next, 0);
        check_eq("rst_req", bus.mem_req, 0);
        check_eq("rst_valid", bus.instr_valid, 0);
        check_eq("rst_instr", bus.instr_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_retired", retired, 0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        check_eq("idle_norun_req", bus.mem_req, 0);
        check_eq("idle_norun_busy", busy, 0);

        // Sequential run, halt pulse during FETCH at PC=2.
        run = 1'b1;
        tick;
        do_instr(8'h00, 0, 0, 1'b0, 8'h00, 1'b0, 8'h01);
        tick;
        check_eq("seq_retired1", retired, exp_retired);
        do_instr(8'h01, 0, 0, 1'b0, 8'h00, 1'b0, 8'h02);
        tick;
        do_instr(8'h02, 0, 0, 1'b0, 8'h00, 1'b1, 8'h03);
        tick;
        check_eq("halt_busy", busy, 0);
        check_eq("halt_req_low", bus.mem_req, 0);
        check_eq("halt_pc", bus.pc_value, 8'h03);
        check_eq("halt_retired", retired, 3);
        check_eq("halt_we", bus.pc_we, 0);

        // halt_req in IDLE blocks the start but is not remembered.
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        check_eq("idle_halt_busy", busy, 0);
        check_eq("idle_halt_req", bus.mem_req, 0);
        tick;
        do_instr(8'h03, 0, 0, 1'b0, 8'h00, 1'b0, 8'h04);
        tick;
        check_eq("nolatch_busy", busy, 1);
        do_instr(8'h04, 0, 0, 1'b0, 8'h00, 1'b0, 8'h05);
        tick;

        // Jump at PC=5, then backpressure with ignored stall-cycle jumps, then wrap.
        do_instr(8'h05, 0, 0, 1'b1, 8'h40, 1'b0, 8'h40);
        tick;
        do_instr(8'h40, 3, 2, 1'b0, 8'h00, 1'b0, 8'h41);
        tick;
        do_instr(8'h41, 0, 0, 1'b1, 8'hFF, 1'b0, 8'hFF);
        tick;
        run = 1'b0;
        do_instr(8'hFF, 0, 0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick;
        check_eq("rundrop_busy", busy, 0);
        check_eq("wrap_pc", bus.pc_value, 8'h00);
        check_eq("rundrop_retired", retired, exp_retired);
        tick;
        check_eq("rundrop_idle_req", bus.mem_req, 0);

        // Async reset in UPDATE1 drops pc_we and retired with no clock edge.
        run = 1'b1;
        tick;
        check_eq("restart_addr", bus.mem_addr, 8'h00);
        bus.mem_ack = 1'b1;
        tick;
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b1;
        tick;
        bus.instr_ready = 1'b0;
        check_eq("upd1_pre_rst_we", bus.pc_we, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_we", bus.pc_we, 0);
        check_eq("async_retired", retired, 0);
        check_eq("async_busy", busy, 0);
        rst = 1'b0;

        // Fetch timeout: 15 FETCH cycles without ack, then sticky FAULT.
        tick;
        check_eq("to_req0", bus.mem_req, 1);
        for (int i = 0; i < 14; i++) begin
            run = ~run;
            tick;
            check_eq("to_wait_fault", fault, 0);
            check_eq("to_wait_req", bus.mem_req, 1);
        end
        tick;
        check_eq("to_fault", fault, 1);
        check_eq("to_busy", busy, 0);
        check_eq("to_req", bus.mem_req, 0);
        check_eq("to_we", bus.pc_we, 0);
        for (int i = 0; i < 4; i++) begin
            run         = ~run;
            bus.mem_ack = 1'b1;
            tick;
            check_eq("fault_sticky", fault, 1);
            check_eq("fault_req", bus.mem_req, 0);
            check_eq("fault_busy", busy, 0);
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_fault", fault, 0);
        check_eq("async_fault_retired", retired, 0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Sequences the 8-bit program counter register through a fetch / dispatch / update cycle. It fetches the instruction at the current PC over a req/ack memory handshake and hands it to the decoder over a valid/ready handshake. It then computes the next PC (sequential increment or decoder-supplied jump) and drives the PC register's write port. It sits between the PC register, instruction memory and the decoder, and owns start/halt control of the core.

Parameters:
FETCH_TIMEOUT, 15, max cycles FETCH waits for mem_ack before raising fault; legal range 1..255.
COUNT_W, 16, width of retired-instruction counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  level; 1 = core may execute
halt_req  input  1  single-cycle pulse; stop after current instruction completes
pc_value  input  8  current PC register output
pc_we  output  1  PC register write_enable
pc_next  output  8  PC register data_in
mem_req  output  1  instruction fetch request
mem_addr  output  8  fetch address (= pc_value while mem_req)
mem_ack  input  1  fetch complete; mem_rdata valid this cycle
mem_rdata  input  8  fetched instruction byte
instr_valid  output  1  instr_out holds an undelivered instruction
instr_out  output  8  instruction to decoder
instr_ready  input  1  decoder accepts instruction
jump_valid  input  1  sampled with instr handshake: redirect PC
jump_target  input  8  redirect address
busy  output  1  state != IDLE and != FAULT
fault  output  1  fetch timeout occurred; sticky until rst
retired  output  COUNT_W  instructions completed since reset

Behaviour:
- States: IDLE, FETCH, DISPATCH, UPDATE1, UPDATE2, FAULT. Reset (async, immediate) -> IDLE.
- Reset values: pc_we=0, pc_next=0, mem_req=0, instr_valid=0, instr_out=0, busy=0, fault=0, retired=0, halt_pend=0, timeout counter=0.
- IDLE: all handshake outputs 0. Go to FETCH when run=1 and halt_req=0 (halt_req with run in IDLE is ignored, not latched).
- FETCH: mem_req=1, mem_addr=pc_value. On mem_ack: register instr_out<=mem_rdata and go to DISPATCH. Otherwise increment the timeout counter. When the counter reaches FETCH_TIMEOUT without ack: fault<=1 and go to FAULT. The counter clears on leaving FETCH. mem_ack outside FETCH is ignored.
- DISPATCH: instr_valid=1, instr_out stable until handshake. On instr_valid&instr_ready, capture next = jump_valid ? jump_target : pc_value+1 (8-bit wrap, 8'hFF -> 8'h00). Then go to UPDATE1. jump_valid outside the handshake cycle is ignored.
- PC write protocol: the PC register ignores the first cycle of any write_enable assertion. Every update therefore holds pc_we=1 for exactly two consecutive cycles (UPDATE1, UPDATE2) with pc_next constant. pc_value shows the new PC on the cycle after UPDATE2. pc_we is 0 in every other state. pc_next holds its last value when not writing.
- UPDATE2 exit: retired increments (wraps at 2^COUNT_W). If halt_pend=1 or run=0, go to IDLE and clear halt_pend. Otherwise go to FETCH.
- halt_req: pulse in any state other than IDLE/FAULT sets halt_pend. The in-flight instruction still completes and the PC still updates. halt_req on the UPDATE2 cycle itself takes effect at that exit.
- run dropping mid-instruction does not abort. The stop takes effect at UPDATE2 exit.
- FAULT: all outputs as IDLE except fault=1. Only rst leaves FAULT.
- Minimum instruction latency with ack and ready in their first cycle: 4 cycles (FETCH, DISPATCH, UPDATE1, UPDATE2).
- rst mid-UPDATE1 drops pc_we immediately. The PC register is reset by the same rst.

Test Plan:
- Sequential run: rst, run=1, mem_ack/instr_ready always 1, jump_valid=0 -> pc_we pulses 2 cycles per instr, pc_value 0,1,2,3 every 4 cycles, retired=3 after 12 cycles.
- Jump: at PC=5 assert jump_valid with jump_target=8'h40 on handshake -> pc_next=8'h40 for UPDATE1/UPDATE2, next mem_addr=8'h40.
- Wrap: PC=8'hFF, no jump -> pc_next=8'h00, fetch resumes at 0.
- Backpressure: mem_ack delayed 3 cycles, instr_ready delayed 2 -> mem_req held 4 cycles, instr_out stable while instr_valid, pc_we never asserted before handshake.
- Halt: halt_req pulse during FETCH at PC=2 -> instruction completes, PC=3, state IDLE, busy=0, no further mem_req while run=1 until next IDLE->FETCH (immediately next cycle since run=1).
- Timeout/reset: mem_ack never arrives -> fault=1 after 15 FETCH cycles, busy=0, run toggling has no effect. Async rst mid-cycle clears fault, pc_we and retired without a clock edge.
